multisim_axi_txn_limiter: RTL and testbench
===========================================

Name: multisim_axi_txn_limiter

Overview:
- Sits directly upstream of the AXI push client, between the local AXI manager and the client's subordinate AXI port.
- Caps outstanding write and read transactions so that the cross-simulation channel never holds more in-flight work than the remote server can absorb.
- Holds W beats until their AW has been accepted.
- Provides a drain request and an idle indication for quiescing before checkpoint or shutdown.

Parameters:
- axi_aw_t, axi_w_t, axi_b_t, axi_ar_t, axi_r_t: type, no default; AXI channel payload structs. axi_w_t must contain field `last`; axi_r_t must contain field `last`.
- MAX_WR_OUTSTANDING, 8: maximum accepted AW without a returned B (1..255).
- MAX_RD_OUTSTANDING, 8: maximum accepted AR without a returned R-last (1..255).
- CNT_W, $clog2(max(MAX_WR_OUTSTANDING, MAX_RD_OUTSTANDING)+1): counter width (localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_drain  in  1  block new AW/AR while high
- s_* (upstream manager side): i_axi_s_aw/awvalid/o_axi_s_awready, i_axi_s_w/wvalid/o_axi_s_wready, o_axi_s_b/bvalid/i_axi_s_bready, i_axi_s_ar/arvalid/o_axi_s_arready, o_axi_s_r/rvalid/i_axi_s_rready  widths: $bits(type) and 1  subordinate AXI port
- m_* (downstream, to push client): o_axi_m_aw/awvalid/i_axi_m_awready, o_axi_m_w/wvalid/i_axi_m_wready, i_axi_m_b/bvalid/o_axi_m_bready, o_axi_m_ar/arvalid/i_axi_m_arready, i_axi_m_r/rvalid/o_axi_m_rready  mirror widths  manager AXI port
- o_wr_outstanding  out  CNT_W  current write counter
- o_rd_outstanding  out  CNT_W  current read counter
- o_idle  out  1  all counters zero
- o_err  out  1  sticky underflow error

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- All payloads pass through combinationally; zero added latency. Only valid/ready are gated.
- wr_cnt tracks outstanding writes:
  - +1 on downstream AW handshake.
  - −1 on upstream B handshake.
  - Both in the same cycle: unchanged.
- aw_ok = (wr_cnt < MAX_WR_OUTSTANDING) && !i_drain.
  - m_awvalid = s_awvalid & aw_ok.
  - s_awready = m_awready & aw_ok.
  - Valid never depends on ready.
- w_cred counts AW accepted whose W burst is not yet complete:
  - +1 on AW handshake.
  - −1 on W handshake with last=1.
  - Both in the same cycle: unchanged.
  - w_ok = (w_cred != 0); m_wvalid = s_wvalid & w_ok; s_wready = m_wready & w_ok.
  - W arriving in the same cycle as its AW waits one cycle (uses registered w_cred only).
- rd_cnt tracks outstanding reads:
  - +1 on AR handshake.
  - −1 on upstream R handshake with last=1.
  - ar_ok is analogous to aw_ok, using MAX_RD_OUTSTANDING.
- B and R pass through unconditionally: s_bvalid = m_bvalid, m_bready = s_bready (same for R).
- Underflow:
  - B handshake with wr_cnt==0, or R-last handshake with rd_cnt==0, sets o_err.
  - o_err stays set until rst.
  - The counter holds at 0.
- Invariant: w_cred ≤ wr_cnt. A W-last handshake with w_cred==0 cannot occur because of gating.
- Drain:
  - i_drain blocks only AW/AR. W, B and R continue, so in-flight transactions complete.
  - Deasserting i_drain resumes acceptance in the same cycle.
- o_idle = (wr_cnt==0) && (rd_cnt==0) && (w_cred==0), registered-state based.
- Reset values:
  - Counters 0; o_err 0; o_idle 1.
  - Output valids follow inputs gated by reset-state counters. While rst is high, all m_/s_ valid and ready outputs are forced 0.
- Reset mid-operation: counters clear; in-flight responses arriving after reset raise o_err. Reset of the downstream client must coincide with this block's reset.

Decomposition:
- No new package types. Channel structs come from the user's AXI package.
- One sub-module: multisim_txn_counter, a saturating up/down counter with MAX parameter, inc/dec inputs, an underflow pulse output and a full flag. Instantiated three times (wr, w_cred, rd).

Test Plan:
- MAX_WR=2, three back-to-back AW with awready=1, no B → AW1 and AW2 accepted, AW3 stalled, o_wr_outstanding=2; one B handshake → AW3 accepted the next cycle, count stays 2.
- W presented before AW (wvalid=1, awvalid=0 for 5 cycles) → s_wready=0 throughout; AW accepted at cycle 5 → W forwarded at cycle 6; 4-beat burst → w_cred returns to 0 after last.
- AR accepted while R-last handshakes in the same cycle at rd_cnt=1 → rd_cnt stays 1; R beats with last=0 do not decrement.
- i_drain=1 with 2 writes and 1 read outstanding → no new AW/AR accepted, B/R still pass; after the final responses, o_idle=1.
- Spurious B with wr_cnt=0 → o_err=1 next cycle and stays set; wr_cnt stays 0; rst clears it.
- Assert rst for 1 cycle with counts 3/2 → all counters 0, o_idle=1, all valid/ready outputs 0 during rst.

Source files
------------

// File: rtl/multisim_axi_txn_limiter_pkg.sv
// Shared helpers for the AXI transaction limiter slice.
// No latency: constants and elaboration-time functions only.
// No backpressure: nothing here carries traffic.
package multisim_axi_txn_limiter_pkg;

    // Largest outstanding cap a counter is meant to hold; keeps counters at most 8 bits.
    localparam int TXN_LIMIT_CEILING = 255;

    // Larger of two caps, used to size the shared counter width.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/multisim_txn_counter.sv
// Saturating up/down transaction counter with full flag and underflow pulse.
// Count updates one cycle after inc/dec; full and underflow are combinational.
// No backpressure: the caller gates inc with full; dec at zero only raises underflow.
module multisim_txn_counter
    import multisim_axi_txn_limiter_pkg::*;
#(
    parameter int MAX = 8,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         underflow
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Count register: simultaneous inc and dec cancel; never wraps in either direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    // Flags derived from the registered count only.
    always_comb begin
        full      = (count >= MAX_V);
        underflow = dec && (count == '0);
    end

endmodule

// File: rtl/multisim_axi_txn_limiter.sv
// Caps outstanding AXI writes/reads ahead of the push client; holds W until its AW is accepted.
// Zero latency: payloads and valid/ready pass combinationally, only valid/ready are gated.
// AW/AR stall when the cap is reached or drain is requested; W stalls without AW credit; B/R never stall here.
module multisim_axi_txn_limiter
    import multisim_axi_txn_limiter_pkg::*;
#(
    parameter type axi_aw_t = logic [31:0],
    parameter type axi_w_t  = struct packed { logic [31:0] data; logic last; },
    parameter type axi_b_t  = logic [1:0],
    parameter type axi_ar_t = logic [31:0],
    parameter type axi_r_t  = struct packed { logic [31:0] data; logic last; },
    parameter int  MAX_WR_OUTSTANDING = 8,
    parameter int  MAX_RD_OUTSTANDING = 8,
    localparam int CNT_W = $clog2(max_int(MAX_WR_OUTSTANDING, MAX_RD_OUTSTANDING) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_drain,

    input  axi_aw_t          i_axi_s_aw,
    input  logic             i_axi_s_awvalid,
    output logic             o_axi_s_awready,
    input  axi_w_t           i_axi_s_w,
    input  logic             i_axi_s_wvalid,
    output logic             o_axi_s_wready,
    output axi_b_t           o_axi_s_b,
    output logic             o_axi_s_bvalid,
    input  logic             i_axi_s_bready,
    input  axi_ar_t          i_axi_s_ar,
    input  logic             i_axi_s_arvalid,
    output logic             o_axi_s_arready,
    output axi_r_t           o_axi_s_r,
    output logic             o_axi_s_rvalid,
    input  logic             i_axi_s_rready,

    output axi_aw_t          o_axi_m_aw,
    output logic             o_axi_m_awvalid,
    input  logic             i_axi_m_awready,
    output axi_w_t           o_axi_m_w,
    output logic             o_axi_m_wvalid,
    input  logic             i_axi_m_wready,
    input  axi_b_t           i_axi_m_b,
    input  logic             i_axi_m_bvalid,
    output logic             o_axi_m_bready,
    output axi_ar_t          o_axi_m_ar,
    output logic             o_axi_m_arvalid,
    input  logic             i_axi_m_arready,
    input  axi_r_t           i_axi_m_r,
    input  logic             i_axi_m_rvalid,
    output logic             o_axi_m_rready,

    output logic [CNT_W-1:0] o_wr_outstanding,
    output logic [CNT_W-1:0] o_rd_outstanding,
    output logic             o_idle,
    output logic             o_err
);

    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] w_cred;
    logic             wr_full;
    logic             rd_full;
    logic             w_cred_full;
    logic             wr_underflow;
    logic             rd_underflow;
    logic             w_cred_underflow;

    logic aw_ok;
    logic ar_ok;
    logic w_ok;
    logic aw_hs;
    logic w_last_hs;
    logic b_hs;
    logic ar_hs;
    logic r_last_hs;

    // Payloads are wired straight through; only handshakes are qualified.
    always_comb begin
        o_axi_m_aw = i_axi_s_aw;
        o_axi_m_w  = i_axi_s_w;
        o_axi_m_ar = i_axi_s_ar;
        o_axi_s_b  = i_axi_m_b;
        o_axi_s_r  = i_axi_m_r;
    end

    // Admission gating from registered counters; rst silences every valid/ready so nothing
    // can handshake while state is being cleared. W uses only the registered credit, so a
    // W beat arriving alongside its own AW waits one cycle.
    always_comb begin
        aw_ok = !wr_full && !i_drain && !rst;
        ar_ok = !rd_full && !i_drain && !rst;
        w_ok  = (w_cred != '0) && !rst;

        o_axi_m_awvalid = i_axi_s_awvalid & aw_ok;
        o_axi_s_awready = i_axi_m_awready & aw_ok;
        o_axi_m_wvalid  = i_axi_s_wvalid  & w_ok;
        o_axi_s_wready  = i_axi_m_wready  & w_ok;
        o_axi_m_arvalid = i_axi_s_arvalid & ar_ok;
        o_axi_s_arready = i_axi_m_arready & ar_ok;

        o_axi_s_bvalid  = i_axi_m_bvalid & !rst;
        o_axi_m_bready  = i_axi_s_bready & !rst;
        o_axi_s_rvalid  = i_axi_m_rvalid & !rst;
        o_axi_m_rready  = i_axi_s_rready & !rst;

        aw_hs     = o_axi_m_awvalid & i_axi_m_awready;
        w_last_hs = o_axi_m_wvalid  & i_axi_m_wready & i_axi_s_w.last;
        b_hs      = o_axi_s_bvalid  & i_axi_s_bready;
        ar_hs     = o_axi_m_arvalid & i_axi_m_arready;
        r_last_hs = o_axi_s_rvalid  & i_axi_s_rready & i_axi_m_r.last;
    end

    multisim_txn_counter #(
        .MAX (MAX_WR_OUTSTANDING),
        .W   (CNT_W)
    ) u_wr_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (aw_hs),
        .dec       (b_hs),
        .count     (wr_cnt),
        .full      (wr_full),
        .underflow (wr_underflow)
    );

    // W credit can never exceed the write count, so it shares the write cap.
    multisim_txn_counter #(
        .MAX (MAX_WR_OUTSTANDING),
        .W   (CNT_W)
    ) u_w_cred (
        .clk       (clk),
        .rst       (rst),
        .inc       (aw_hs),
        .dec       (w_last_hs),
        .count     (w_cred),
        .full      (w_cred_full),
        .underflow (w_cred_underflow)
    );

    multisim_txn_counter #(
        .MAX (MAX_RD_OUTSTANDING),
        .W   (CNT_W)
    ) u_rd_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (ar_hs),
        .dec       (r_last_hs),
        .count     (rd_cnt),
        .full      (rd_full),
        .underflow (rd_underflow)
    );

    // Sticky error: any response with nothing outstanding. W credit underflow is
    // unreachable through the gating but folded in as a defensive catch.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (wr_underflow || rd_underflow || (w_cred_underflow && !w_cred_full)) begin
            o_err <= 1'b1;
        end
    end

    // Status taken purely from registered counter state.
    always_comb begin
        o_wr_outstanding = wr_cnt;
        o_rd_outstanding = rd_cnt;
        o_idle           = (wr_cnt == '0) && (rd_cnt == '0) && (w_cred == '0);
    end

endmodule

// File: tb/tb_multisim_axi_txn_limiter.sv
module tb_multisim_axi_txn_limiter;

    typedef struct packed { logic [7:0] addr; } aw_t;
    typedef struct packed { logic [7:0] data; logic last; } w_t;
    typedef logic [1:0] b_t;
    typedef struct packed { logic [7:0] addr; } ar_t;
    typedef struct packed { logic [7:0] data; logic last; } r_t;

    logic clk = 1'b0;
    logic rst;
    logic drain;
    aw_t  s_aw;  logic s_awvalid; logic s_awready;
    w_t   s_w;   logic s_wvalid;  logic s_wready;
    b_t   s_b;   logic s_bvalid;  logic s_bready;
    ar_t  s_ar;  logic s_arvalid; logic s_arready;
    r_t   s_r;   logic s_rvalid;  logic s_rready;
    aw_t  m_aw;  logic m_awvalid; logic m_awready;
    w_t   m_w;   logic m_wvalid;  logic m_wready;
    b_t   m_b;   logic m_bvalid;  logic m_bready;
    ar_t  m_ar;  logic m_arvalid; logic m_arready;
    r_t   m_r;   logic m_rvalid;  logic m_rready;
    logic [1:0] wr_out;
    logic [1:0] rd_out;
    logic idle;
    logic err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multisim_axi_txn_limiter #(
        .axi_aw_t (aw_t), .axi_w_t (w_t), .axi_b_t (b_t), .axi_ar_t (ar_t), .axi_r_t (r_t),
        .MAX_WR_OUTSTANDING (2),
        .MAX_RD_OUTSTANDING (3)
    ) dut (
        .clk (clk), .rst (rst), .i_drain (drain),
        .i_axi_s_aw (s_aw), .i_axi_s_awvalid (s_awvalid), .o_axi_s_awready (s_awready),
        .i_axi_s_w (s_w), .i_axi_s_wvalid (s_wvalid), .o_axi_s_wready (s_wready),
        .o_axi_s_b (s_b), .o_axi_s_bvalid (s_bvalid), .i_axi_s_bready (s_bready),
        .i_axi_s_ar (s_ar), .i_axi_s_arvalid (s_arvalid), .o_axi_s_arready (s_arready),
        .o_axi_s_r (s_r), .o_axi_s_rvalid (s_rvalid), .i_axi_s_rready (s_rready),
        .o_axi_m_aw (m_aw), .o_axi_m_awvalid (m_awvalid), .i_axi_m_awready (m_awready),
        .o_axi_m_w (m_w), .o_axi_m_wvalid (m_wvalid), .i_axi_m_wready (m_wready),
        .i_axi_m_b (m_b), .i_axi_m_bvalid (m_bvalid), .o_axi_m_bready (m_bready),
        .o_axi_m_ar (m_ar), .o_axi_m_arvalid (m_arvalid), .i_axi_m_arready (m_arready),
        .i_axi_m_r (m_r), .i_axi_m_rvalid (m_rvalid), .o_axi_m_rready (m_rready),
        .o_wr_outstanding (wr_out), .o_rd_outstanding (rd_out),
        .o_idle (idle), .o_err (err)
    );

    typedef struct {
        logic drain, awv, wv, wl, bv, arv, rv, rl;
        logic e_mawv, e_mwv, e_marv;
        int   e_wr, e_rd;
        logic e_err, e_idle;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        drain = 0; s_awvalid = 0; s_wvalid = 0; s_w = '0; m_bvalid = 0;
        s_arvalid = 0; m_rvalid = 0; m_r = '0;
        m_awready = 1; m_wready = 1; m_arready = 1; s_bready = 1; s_rready = 1;
    endtask

    // Called at posedge+1; advances to the next posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // drain awv wv wl bv arv rv rl | mawv mwv marv  wr rd err idle
        tbl[0]  = '{0,1,0,0,0,0,0,0, 1,0,0, 1,0, 0,0};
        tbl[1]  = '{0,1,1,1,0,0,0,0, 1,1,0, 2,0, 0,0};
        tbl[2]  = '{0,1,1,1,0,0,0,0, 0,1,0, 2,0, 0,0};
        tbl[3]  = '{0,1,1,0,0,0,0,0, 0,0,0, 2,0, 0,0};
        tbl[4]  = '{0,1,0,0,1,0,0,0, 0,0,0, 1,0, 0,0};
        tbl[5]  = '{0,1,0,0,0,0,0,0, 1,0,0, 2,0, 0,0};
        tbl[6]  = '{0,0,1,1,0,0,0,0, 0,1,0, 2,0, 0,0};
        tbl[7]  = '{0,0,0,0,1,0,0,0, 0,0,0, 1,0, 0,0};
        tbl[8]  = '{0,0,0,0,1,0,0,0, 0,0,0, 0,0, 0,1};
        tbl[9]  = '{0,0,0,0,0,1,0,0, 0,0,1, 0,1, 0,0};
        tbl[10] = '{0,0,0,0,0,1,1,1, 0,0,1, 0,1, 0,0};
        tbl[11] = '{0,0,0,0,0,0,1,0, 0,0,0, 0,1, 0,0};
        tbl[12] = '{0,0,0,0,0,0,1,1, 0,0,0, 0,0, 0,1};
        tbl[13] = '{0,1,0,0,0,1,0,0, 1,0,1, 1,1, 0,0};
        tbl[14] = '{1,1,0,0,0,1,0,0, 0,0,0, 1,1, 0,0};
        tbl[15] = '{1,0,0,0,1,0,1,1, 0,0,0, 0,0, 0,0};
        tbl[16] = '{1,0,1,1,0,0,0,0, 0,1,0, 0,0, 0,1};
        tbl[17] = '{0,1,0,0,0,0,0,0, 1,0,0, 1,0, 0,0};
        tbl[18] = '{0,0,1,1,1,0,0,0, 0,1,0, 0,0, 0,1};
        tbl[19] = '{0,0,0,0,1,0,0,0, 0,0,0, 0,0, 1,1};
        tbl[20] = '{0,0,0,0,0,0,0,0, 0,0,0, 0,0, 1,1};

        s_aw = 8'h5a; s_ar = 8'ha5; m_b = 2'b10;
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("reset_wr", int'(wr_out), 0);
        chk("reset_rd", int'(rd_out), 0);
        chk("reset_idle", int'(idle), 1);
        chk("reset_err", int'(err), 0);
        chk("aw_payload", int'(m_aw), 8'h5a);
        chk("ar_payload", int'(m_ar), 8'ha5);
        chk("b_payload", int'(s_b), 2);
        #1;

        // Table-driven main sequence, all readies high.
        for (int i = 0; i < 21; i++) begin
            drain = tbl[i].drain; s_awvalid = tbl[i].awv; s_wvalid = tbl[i].wv;
            s_w.last = tbl[i].wl; s_w.data = 8'(i); m_bvalid = tbl[i].bv;
            s_arvalid = tbl[i].arv; m_rvalid = tbl[i].rv; m_r.last = tbl[i].rl;
            #1;
            chk($sformatf("v%0d_m_awvalid", i), int'(m_awvalid), int'(tbl[i].e_mawv));
            chk($sformatf("v%0d_m_wvalid", i), int'(m_wvalid), int'(tbl[i].e_mwv));
            chk($sformatf("v%0d_m_arvalid", i), int'(m_arvalid), int'(tbl[i].e_marv));
            chk($sformatf("v%0d_s_bvalid", i), int'(s_bvalid), int'(tbl[i].bv));
            chk($sformatf("v%0d_s_rvalid", i), int'(s_rvalid), int'(tbl[i].rv));
            tick();
            chk($sformatf("v%0d_wr", i), int'(wr_out), tbl[i].e_wr);
            chk($sformatf("v%0d_rd", i), int'(rd_out), tbl[i].e_rd);
            chk($sformatf("v%0d_err", i), int'(err), int'(tbl[i].e_err));
            chk($sformatf("v%0d_idle", i), int'(idle), int'(tbl[i].e_idle));
        end

        // Reset clears the sticky error.
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("err_cleared", int'(err), 0);
        chk("wr_after_clear", int'(wr_out), 0);

        // Downstream AW backpressure: valid still forwarded, upstream ready low, no count.
        s_awvalid = 1; m_awready = 0;
        #1;
        chk("bp_m_awvalid", int'(m_awvalid), 1);
        chk("bp_s_awready", int'(s_awready), 0);
        tick();
        chk("bp_wr", int'(wr_out), 0);
        s_awvalid = 0; m_awready = 1;

        // W presented before AW: held for five cycles.
        s_wvalid = 1; s_w.last = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("w_early_%0d_s_wready", c), int'(s_wready), 0);
            chk($sformatf("w_early_%0d_m_wvalid", c), int'(m_wvalid), 0);
            tick();
        end
        // AW accepted in cycle 5; W still waits on the registered credit.
        s_awvalid = 1;
        #1;
        chk("w_same_cycle_s_wready", int'(s_wready), 0);
        chk("w_same_cycle_m_awvalid", int'(m_awvalid), 1);
        tick();
        s_awvalid = 0;
        for (int b = 0; b < 4; b++) begin
            s_w.last = (b == 3);
            #1;
            chk($sformatf("burst_%0d_s_wready", b), int'(s_wready), 1);
            chk($sformatf("burst_%0d_m_wvalid", b), int'(m_wvalid), 1);
            tick();
        end
        s_w.last = 0;
        #1;
        chk("post_burst_s_wready", int'(s_wready), 0);
        chk("post_burst_wr", int'(wr_out), 1);
        chk("post_burst_idle", int'(idle), 0);
        s_wvalid = 0; m_bvalid = 1;
        tick();
        m_bvalid = 0;
        chk("burst_done_idle", int'(idle), 1);

        // Build wr=2, rd=3 then a one-cycle reset with everything driven high.
        s_awvalid = 1; s_arvalid = 1;
        tick();
        tick();
        s_awvalid = 0;
        tick();
        s_arvalid = 0;
        chk("pre_rst_wr", int'(wr_out), 2);
        chk("pre_rst_rd", int'(rd_out), 3);
        rst = 1;
        s_awvalid = 1; s_wvalid = 1; m_bvalid = 1; s_arvalid = 1; m_rvalid = 1;
        #1;
        chk("rst_valids", int'({m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid}), 0);
        chk("rst_readies", int'({s_awready, s_wready, m_bready, s_arready, m_rready}), 0);
        tick();
        rst = 0;
        idle_inputs();
        #1;
        chk("post_rst_wr", int'(wr_out), 0);
        chk("post_rst_rd", int'(rd_out), 0);
        chk("post_rst_idle", int'(idle), 1);
        chk("post_rst_err", int'(err), 0);
        // Late response for a transaction that the reset discarded.
        m_rvalid = 1; m_r.last = 1;
        tick();
        m_rvalid = 0;
        chk("late_r_err", int'(err), 1);
        chk("late_r_rd", int'(rd_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
